// File: rtl/dcm_pkg.sv
// Shared types and the program-code to half-period multiplier table for the
// multi-channel clock divider.
package dcm_pkg;

  localparam int PROG_W = 3;

  typedef logic [PROG_W-1:0] prog_t;

  function automatic logic [7:0] mult_of(input prog_t code);
    logic [7:0] m;
    case (code)
      3'd0:    m = 8'd1;
      3'd1:    m = 8'd2;
      3'd2:    m = 8'd4;
      3'd3:    m = 8'd10;
      3'd4:    m = 8'd16;
      3'd5:    m = 8'd32;
      3'd6:    m = 8'd64;
      default: m = 8'd128;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dcm_multi_if.sv
// Update request and status bus of the multi-channel clock divider.
interface dcm_multi_if #(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 3
);
  import dcm_pkg::*;

  logic                     update_clock;
  logic [SEL_W-1:0]         ch_sel;
  prog_t                    prog_in;
  logic [PROG_W*NUM_CH-1:0] prog_out;
  logic [NUM_CH-1:0]        clock_out;
  logic [NUM_CH-1:0]        tick;
  logic [NUM_CH-1:0]        pending;
  logic [NUM_CH-1:0]        update_ack;
  logic                     update_err;

  modport master (
    output update_clock, ch_sel, prog_in,
    input  prog_out, clock_out, tick, pending, update_ack, update_err
  );

  modport slave (
    input  update_clock, ch_sel, prog_in,
    output prog_out, clock_out, tick, pending, update_ack, update_err
  );

endinterface

// File: rtl/dcm_channel.sv
// One divider channel: half-period counter, output toggle, and a pending
// program that is swapped in at the next toggle.
module dcm_channel
  import dcm_pkg::*;
#(
  parameter int BASE_COUNT = 5_000_000,
  parameter int CNT_W      = 30
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  wr,
  input  prog_t prog_in,
  output prog_t active,
  output logic  clock_out,
  output logic  tick,
  output logic  pending,
  output logic  ack
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_COUNT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic             terminal;
  prog_t            pend_val;

  always_comb begin
    half     = BASE * CNT_W'(mult_of(active));
    terminal = (cnt == half - CNT_W'(1));
  end

  // A write landing on a terminal edge is only captured: the apply uses the
  // pre-edge pending flag/value, while the write re-arms pending afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      active    <= '0;
      pend_val  <= '0;
      pending   <= 1'b0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
      ack       <= 1'b0;
    end else begin
      tick <= terminal;
      ack  <= terminal && pending;
      if (terminal) begin
        cnt       <= '0;
        clock_out <= ~clock_out;
        if (pending) active <= pend_val;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (wr) pend_val <= prog_in;
      if (wr)            pending <= 1'b1;
      else if (terminal) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/dcm_multi.sv
// Multi-channel programmable clock divider: channel-select decode, error
// flag and output packing around NUM_CH independent dcm_channel instances.
module dcm_multi
  import dcm_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int BASE_COUNT = 5_000_000,
  parameter int CNT_W      = 30,
  parameter int SEL_W      = 3
) (
  input logic         clock,
  input logic         reset,
  dcm_multi_if.slave  bus
);

  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] wr_v;
  logic [NUM_CH-1:0] clk_v;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] ack_v;
  prog_t             act_v [NUM_CH];
  logic              err_q;

  always_comb begin
    wr_v = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_v[i] = bus.update_clock && ({1'b0, bus.ch_sel} == (SEL_W + 1)'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= bus.update_clock && ({1'b0, bus.ch_sel} >= NUM_CH_W);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dcm_channel #(
      .BASE_COUNT (BASE_COUNT),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .wr        (wr_v[g]),
      .prog_in   (bus.prog_in),
      .active    (act_v[g]),
      .clock_out (clk_v[g]),
      .tick      (tick_v[g]),
      .pending   (pend_v[g]),
      .ack       (ack_v[g])
    );
  end

  always_comb begin
    bus.prog_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      bus.prog_out[PROG_W*i +: PROG_W] = act_v[i];
    end
  end

  assign bus.clock_out  = clk_v;
  assign bus.tick       = tick_v;
  assign bus.pending    = pend_v;
  assign bus.update_ack = ack_v;
  assign bus.update_err = err_q;

endmodule

// File: tb/tb_dcm_multi.sv
// Scoreboard bench for dcm_multi: an event-scheduled reference model predicts
// each cycle's outputs, a monitor pops and compares them after every edge.
module tb_dcm_multi;

  localparam int NCH   = 3;
  localparam int BASE  = 4;
  localparam int CW    = 10;
  localparam int SW    = 2;

  typedef struct {
    logic [NCH-1:0]   clk;
    logic [NCH-1:0]   tck;
    logic [NCH-1:0]   pnd;
    logic [NCH-1:0]   ack;
    logic [3*NCH-1:0] prog;
    logic             err;
  } snap_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  dcm_multi_if #(.NUM_CH(NCH), .SEL_W(SW)) bus ();

  dcm_multi #(
    .NUM_CH     (NCH),
    .BASE_COUNT (BASE),
    .CNT_W      (CW),
    .SEL_W      (SW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  snap_t q[$];

  // Reference model: each channel keeps the absolute edge number of its next toggle.
  int mult_tab [8] = '{1, 2, 4, 10, 16, 32, 64, 128};
  int m_n;
  int m_next [NCH];
  int m_act  [NCH];
  int m_pval [NCH];
  bit m_pend [NCH];
  bit m_lvl  [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    for (int c = 0; c < NCH; c++) begin
      m_act[c]  = 0;
      m_pval[c] = 0;
      m_pend[c] = 1'b0;
      m_lvl[c]  = 1'b0;
      m_next[c] = BASE * mult_tab[0];
    end
  endtask

  task automatic model_step(input bit upd, input int sel, input int prog);
    snap_t s;
    m_n++;
    s.clk = '0; s.tck = '0; s.pnd = '0; s.ack = '0; s.prog = '0;
    s.err = upd && (sel >= NCH);
    for (int c = 0; c < NCH; c++) begin
      if (m_n == m_next[c]) begin
        m_lvl[c] = ~m_lvl[c];
        s.tck[c] = 1'b1;
        if (m_pend[c]) begin
          m_act[c]  = m_pval[c];
          m_pend[c] = 1'b0;
          s.ack[c]  = 1'b1;
        end
        m_next[c] = m_n + BASE * mult_tab[m_act[c]];
      end
      if (upd && sel == c) begin
        m_pval[c] = prog;
        m_pend[c] = 1'b1;
      end
      s.clk[c] = m_lvl[c];
      s.pnd[c] = m_pend[c];
      s.prog[3*c +: 3] = 3'(m_act[c]);
    end
    q.push_back(s);
  endtask

  // Called at a negedge: drive inputs for the coming edge and predict its result.
  task automatic step(input bit upd, input int sel, input int prog);
    bus.update_clock = upd;
    bus.ch_sel       = SW'(sel);
    bus.prog_in      = 3'(prog);
    model_step(upd, sel, prog);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".clock_out"}, 32'(bus.clock_out), 32'd0);
    check({tag, ".tick"},      32'(bus.tick),      32'd0);
    check({tag, ".pending"},   32'(bus.pending),   32'd0);
    check({tag, ".ack"},       32'(bus.update_ack), 32'd0);
    check({tag, ".prog_out"},  32'(bus.prog_out),  32'd0);
    check({tag, ".err"},       32'(bus.update_err), 32'd0);
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      snap_t e;
      e = q.pop_front();
      check("clock_out",  32'(bus.clock_out),  32'(e.clk));
      check("tick",       32'(bus.tick),       32'(e.tck));
      check("pending",    32'(bus.pending),    32'(e.pnd));
      check("update_ack", 32'(bus.update_ack), 32'(e.ack));
      check("prog_out",   32'(bus.prog_out),   32'(e.prog));
      check("update_err", 32'(bus.update_err), 32'(e.err));
    end
  end

  initial begin
    int guard;
    bus.update_clock = 1'b0;
    bus.ch_sel       = '0;
    bus.prog_in      = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    idle(20);
    step(1'b1, 1, 1);
    idle(40);
    step(1'b1, 2, 3);
    step(1'b1, 2, 2);
    idle(60);

    guard = 0;
    while (m_next[0] != m_n + 1 && guard < 1000) begin
      step(1'b0, 0, 0);
      guard++;
    end
    check("terminal_wait", 32'(guard < 1000), 32'd1);
    step(1'b1, 0, 2);
    idle(30);

    step(1'b1, 3, 5);
    idle(5);
    step(1'b1, 0, m_act[0]);
    idle(30);

    step(1'b1, 1, 5);
    idle(2);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_reset();
    idle(30);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0)
        step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      else
        step(1'b0, 0, 0);
    end
    idle(5);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
